load_store_arbiter: RTL and testbench

// Shares one bounded volume counter (0..CAP) between NREQ requesters, each issuing

---
 rtl/load_store_arbiter.sv | 142 ++++++++++++++
 tb/tb_load_store_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/load_store_arbiter.sv
// rtl/load_store_arbiter.sv - round-robin arbiter stepping a shared bounded volume counter.
// Optional LSA_PRIO0_EN: requester 0 overrides round-robin whenever it requests.
module load_store_arbiter #(
  parameter int NREQ  = 4,
  parameter int CAP   = 400000,
  parameter int CBITS = 19,
  parameter int AW    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   is_load,
  input  logic [NREQ*AW-1:0] amt,
  output logic [NREQ-1:0]   gnt,
  output logic              busy,
  output logic              done,
  output logic              short,
  output logic [CBITS-1:0]  vol,
  output logic              full,
  output logic              empty
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [CBITS-1:0] CAPV = CBITS'(CAP);

  typedef enum logic [1:0] {IDLE, XFER, DONE_S} state_t;

  state_t          state, state_n;
  logic [PW-1:0]   ptr, ptr_n;
  logic            dir, dir_n;
  logic [AW-1:0]   rem, rem_n;
  logic [NREQ-1:0] gnt_n;
  logic            busy_n, done_n, short_n;
  logic [CBITS-1:0] vol_n;

  logic [AW-1:0]   amt_a [NREQ];
  logic            found, adv;
  logic [PW-1:0]   win, idx;

  for (genvar i = 0; i < NREQ; i++) begin : g_amt
    assign amt_a[i] = amt[i*AW +: AW];
  end

  assign full  = (vol == CAPV);
  assign empty = (vol == '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      ptr   <= '0;
      dir   <= 1'b0;
      rem   <= '0;
      gnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      short <= 1'b0;
      vol   <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      dir   <= dir_n;
      rem   <= rem_n;
      gnt   <= gnt_n;
      busy  <= busy_n;
      done  <= done_n;
      short <= short_n;
      vol   <= vol_n;
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    dir_n   = dir;
    rem_n   = rem;
    gnt_n   = gnt;
    busy_n  = busy;
    done_n  = 1'b0;
    short_n = short;
    vol_n   = vol;
    found   = 1'b0;
    adv     = 1'b1;
    win     = '0;
    idx     = '0;

`ifdef LSA_PRIO0_EN
    if (req[0]) begin
      found = 1'b1;
      adv   = 1'b0;
    end
`endif
    // First requester at or above the pointer, wrapping around.
    for (int k = 0; k < NREQ; k++) begin
      idx = PW'((int'(ptr) + k) % NREQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end

    case (state)
      IDLE: begin
        if (found) begin
          state_n = XFER;
          gnt_n   = NREQ'(1) << win;
          dir_n   = is_load[win];
          rem_n   = amt_a[win];
          busy_n  = 1'b1;
          short_n = 1'b0;
          if (adv) ptr_n = (int'(win) == NREQ - 1) ? '0 : win + PW'(1);
        end
      end
      XFER: begin
        if (rem == '0) begin
          state_n = DONE_S;
          done_n  = 1'b1;
          short_n = 1'b0;
        end else if ((dir && vol == CAPV) || (!dir && vol == '0)) begin
          state_n = DONE_S;
          done_n  = 1'b1;
          short_n = 1'b1;
        end else begin
          vol_n = dir ? vol + CBITS'(1) : vol - CBITS'(1);
          rem_n = rem - AW'(1);
          if (rem == AW'(1)) begin
            state_n = DONE_S;
            done_n  = 1'b1;
            short_n = 1'b0;
          end
        end
      end
      DONE_S: begin
        state_n = IDLE;
        gnt_n   = '0;
        busy_n  = 1'b0;
        short_n = 1'b0;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_load_store_arbiter.sv
// tb/tb_load_store_arbiter.sv - self-checking bench for load_store_arbiter (NREQ=4, CAP=10).
module tb_load_store_arbiter;

  localparam int NREQ = 4, CAP = 10, CBITS = 4, AW = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ-1:0]   is_load = '0;
  logic [NREQ*AW-1:0] amt = '0;
  logic [NREQ-1:0]   gnt;
  logic              busy, done, short, full, empty;
  logic [CBITS-1:0]  vol;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] gnt;
    int         vol;
    int         sh;
    int         cyc;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    int         idx;
    int         ld;
    int         a;
    int         scr;
    logic [3:0] egnt;
    int         evol;
    int         esh;
    int         ecyc;
  } vec_t;

  vec_t vecs[8];

  load_store_arbiter #(.NREQ(NREQ), .CAP(CAP), .CBITS(CBITS), .AW(AW)) dut (
    .clk(clk), .rst(rst), .req(req), .is_load(is_load), .amt(amt),
    .gnt(gnt), .busy(busy), .done(done), .short(short),
    .vol(vol), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    req = '0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // One transfer on its own; expectations go to the scoreboard at drive time.
  task automatic run_txn(input int idx, input int ld, input int a, input int scr,
                         input logic [3:0] egnt, input int evol, input int esh, input int ecyc);
    exp_t e;
    exp_t got;
    int cyc = 0;
    bit seen = 0;
    e.gnt = egnt; e.vol = evol; e.sh = esh; e.cyc = ecyc;
    @(negedge clk);
    req = 4'(1 << idx);
    is_load = 4'(ld << idx);
    amt = '0;
    amt[idx*AW +: AW] = 8'(a);
    sb.push_back(e);
    for (int t = 0; t < 400 && !seen; t++) begin
      @(negedge clk);
      if (busy && !done) cyc++;
      if (scr != 0 && gnt != '0) begin
        req = '0;
        is_load = ~is_load;
        amt = {NREQ{8'd200}};
      end
      if (done) begin
        seen = 1;
        if (sb.size() == 0) begin
          chk("sb_empty", 1, 0);
        end else begin
          got = sb.pop_front();
          chk("txn_gnt", gnt, got.gnt);
          chk("txn_vol", vol, got.vol);
          chk("txn_short", short, got.sh);
          chk("txn_cycles", cyc, got.cyc);
          chk("txn_full", full, (got.vol == CAP));
        end
        req = '0;
      end
    end
    if (!seen) chk("txn_timeout", 0, 1);
    @(negedge clk);
    chk("post_done", done, 0);
    chk("post_gnt", gnt, 0);
    chk("post_busy", busy, 0);
    chk("post_short", short, 0);
  endtask

  // Requesters in mask all held with amt=1 load; grants compared in order.
  task automatic run_rr(input logic [3:0] mask, input logic [3:0] g0, input logic [3:0] g1,
                        input logic [3:0] g2, input logic [3:0] g3, input logic [3:0] g4, input int n);
    exp_t e;
    exp_t got;
    logic [3:0] gl[5];
    int dones = 0;
    gl[0] = g0; gl[1] = g1; gl[2] = g2; gl[3] = g3; gl[4] = g4;
    @(negedge clk);
    req = mask;
    is_load = 4'hf;
    amt = {NREQ{8'd1}};
    for (int i = 0; i < n; i++) begin
      e.gnt = gl[i]; e.vol = i + 1; e.sh = 0; e.cyc = 1;
      sb.push_back(e);
    end
    for (int t = 0; t < 200 && dones < n; t++) begin
      @(negedge clk);
      if (done) begin
        dones++;
        got = sb.pop_front();
        chk("rr_gnt", gnt, got.gnt);
        chk("rr_vol", vol, got.vol);
      end
    end
    if (dones < n) chk("rr_timeout", dones, n);
    req = '0;
    repeat (3) @(negedge clk);
    sb.delete();
  endtask

  initial begin
    vecs[0] = '{1, 1, 3,   0, 4'b0010, 3,  0, 3};
    vecs[1] = '{2, 1, 5,   0, 4'b0100, 8,  0, 5};
    vecs[2] = '{2, 1, 5,   0, 4'b0100, 10, 1, 3};
    vecs[3] = '{0, 0, 5,   0, 4'b0001, 5,  0, 5};
    vecs[4] = '{3, 0, 0,   0, 4'b1000, 5,  0, 1};
    vecs[5] = '{1, 0, 7,   0, 4'b0010, 0,  1, 6};
    vecs[6] = '{0, 1, 255, 0, 4'b0001, 10, 1, 11};
    vecs[7] = '{3, 0, 2,   1, 4'b1000, 8,  0, 2};

    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_vol", vol, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_gnt", gnt, 0);

    for (int i = 0; i < 8; i++)
      run_txn(vecs[i].idx, vecs[i].ld, vecs[i].a, vecs[i].scr,
              vecs[i].egnt, vecs[i].evol, vecs[i].esh, vecs[i].ecyc);

    do_reset();
`ifdef LSA_PRIO0_EN
    run_rr(4'b1111, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 5);
    do_reset();
    run_rr(4'b0101, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 3);
`else
    run_rr(4'b1111, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 5);
    do_reset();
    run_rr(4'b0101, 4'b0001, 4'b0100, 4'b0001, 4'b0001, 4'b0001, 3);
`endif

    // Reset in the middle of a transfer: vol=4 with two units remaining.
    do_reset();
    run_txn(1, 1, 2, 0, 4'b0010, 2, 0, 2);
    @(negedge clk);
    req = 4'b0100;
    is_load = 4'b0100;
    amt = '0;
    amt[2*AW +: AW] = 8'd4;
    for (int t = 0; t < 50 && vol != 4'd4; t++) @(negedge clk);
    chk("mid_vol_reached", vol, 4);
    chk("mid_busy", busy, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_vol", vol, 0);
    chk("mid_rst_gnt", gnt, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_empty", empty, 1);
    rst = 1'b1;
    req = '0;
    repeat (3) begin
      @(negedge clk);
      chk("mid_no_done", done, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
